led_pulse_stretcher: RTL and testbench
======================================

Name: led_pulse_stretcher

Overview:
- Output-side counterpart of the front-panel button conditioning.
- Converts single-cycle event strobes from control logic into human-visible LED blinks: each event gives a fixed-length on-time followed by a mandatory off-gap.
- Back-to-back events show as distinct blinks instead of merging.
- Sits between controller status strobes (frame done, mode change, button acknowledge) and the board indicator LEDs.

Parameters:
- ON_CYCLES, 5_000_000, LED high time per event in clk cycles (50 ms at 100 MHz); must be >= 1.
- OFF_CYCLES, 5_000_000, forced LED low gap after each blink in clk cycles; must be >= 1.
- QUEUE_MAX, 7, maximum number of events held pending while a blink is in progress; must be >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- pulse  input  1  event strobe; each high cycle is one event.
- led  output  1  registered indicator drive.
- busy  output  1  high whenever state is not IDLE.
- pending  output  $clog2(QUEUE_MAX+1)  number of queued events not yet displayed.
- dropped  output  1  one-cycle strobe when an event is discarded.

Behaviour:
- Reset is clk-synchronous, rst active high. Reset state: IDLE; led=0, busy=0, pending=0, dropped=0, timer=0.
- All outputs are registered or decoded directly from registered state. No combinational path from pulse to any output.
- States:
  - IDLE: led=0. If pulse, go to ON with timer loaded to ON_CYCLES-1.
  - ON: led=1. Timer decrements each cycle; at 0, go to OFF with timer loaded to OFF_CYCLES-1.
  - OFF: led=0. Timer decrements; at 0:
    - if pending>0, or pulse is high this cycle, go to ON with timer reloaded;
    - else go to IDLE.
- Latency: pulse high in cycle k gives led=1 from cycle k+1, for exactly ON_CYCLES cycles, then exactly OFF_CYCLES low cycles.
- Queueing, for a pulse in ON or OFF:
  - If pending<QUEUE_MAX: pending increments.
  - If pending==QUEUE_MAX: pending holds and dropped=1 next cycle.
- OFF-to-ON transition:
  - With pending>0: pending decrements.
  - With pulse in the same cycle as a decrement: net pending unchanged, no drop.
  - With pending==0 and pulse: the pulse is consumed directly, pending stays 0.
- Pulse held high N cycles counts as N events. Callers must supply single-cycle strobes.
- Timer width: $clog2(max(ON_CYCLES,OFF_CYCLES)). Down-counter, never wraps, reloaded only on state entry.
- Reset mid-blink: next cycle led=0, IDLE, pending=0. Queued events are lost.
- A pulse in the same cycle as rst is ignored.

Optional Feature:
- Macro: LED_PULSE_STRETCHER_QUEUE_EN.
- Defined: queueing as above.
- Undefined:
  - No queue register; pending is tied to 0.
  - Any pulse in ON or OFF (except the OFF final-cycle direct consume) is discarded with dropped=1 next cycle.

Decomposition:
- Package led_ind_pkg:
  - typedef enum logic [1:0] {IDLE, ON, OFF} blink_state_t;
  - helper function for max(a,b) used in timer width.
- Sub-module: cycle_timer.
  - Ports: load, load_val, en, done.
  - Parameterised width.
  - Instantiated once for the ON/OFF countdown.

Test Plan (ON_CYCLES=4, OFF_CYCLES=3, QUEUE_MAX=2, macro defined unless noted):
- Reset release, single pulse at cycle 10 -> led high cycles 11-14, low 15-17, IDLE at 18; busy high 11-17.
- Three pulses during the first ON -> pending 1, 2, 2 with dropped=1 once. Then blinks at 11-14 and 18-21 (pending->1), and 25-28 (pending->0). IDLE at 32.
- Pulse exactly in the final OFF cycle with pending=0 -> ON on the next cycle, pending stays 0, no drop.
- Pulse in the final OFF cycle with pending=2 -> pending stays 2, dropped stays 0.
- rst asserted at cycle 12 mid-ON with pending=1 -> cycle 13: led=0, busy=0, pending=0; the next pulse starts a fresh 4-cycle blink.
- Macro undefined: pulse during ON -> dropped=1 for one cycle, pending=0, only one blink produced.

Source files
------------

// File: rtl/led_ind_pkg.sv
// Shared types and width helpers for the LED pulse stretcher.
package led_ind_pkg;

  typedef enum logic [1:0] {IDLE, ON, OFF} blink_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // A one-cycle phase still needs a 1-bit timer register.
  function automatic int unsigned timer_width(input int unsigned on_c,
                                              input int unsigned off_c);
    int unsigned m;
    m = max_u(on_c, off_c);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/led_pulse_stretcher_cycle_timer.sv
// Loadable down-counter that stops at zero; done flags the terminal count.
module cycle_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && (count != '0))
      count <= count - WIDTH'(1);
  end

  assign done = (count == '0);

endmodule

// File: rtl/led_pulse_stretcher.sv
// Stretches single-cycle event strobes into fixed on/off LED blinks.
// Event queueing is built only when LED_PULSE_STRETCHER_QUEUE_EN is defined.
//
// state | meaning
// IDLE  | LED off, waiting for an event
// ON    | LED lit for ON_CYCLES
// OFF   | forced dark gap of OFF_CYCLES before the next blink
module led_pulse_stretcher
  import led_ind_pkg::*;
#(
  parameter int unsigned ON_CYCLES  = 5_000_000,
  parameter int unsigned OFF_CYCLES = 5_000_000,
  parameter int unsigned QUEUE_MAX  = 7
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pulse,
  output logic                           led,
  output logic                           busy,
  output logic [$clog2(QUEUE_MAX+1)-1:0] pending,
  output logic                           dropped
);

  localparam int unsigned TW = timer_width(ON_CYCLES, OFF_CYCLES);
  localparam int unsigned PW = $clog2(QUEUE_MAX + 1);
  localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);

  blink_state_t    state, state_nx;
  logic            tmr_load, tmr_en, tmr_done;
  logic [TW-1:0]   tmr_val;
  logic            consume, queue_req, drop_nx;
  logic [PW-1:0]   pend_q;

  cycle_timer #(.WIDTH(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .done     (tmr_done)
  );

  assign tmr_en = (state != IDLE);

  always_comb begin
    state_nx  = state;
    tmr_load  = 1'b0;
    tmr_val   = ON_LOAD;
    consume   = 1'b0;
    queue_req = 1'b0;
    case (state)
      IDLE: begin
        if (pulse) begin
          state_nx = ON;
          tmr_load = 1'b1;
        end
      end
      ON: begin
        queue_req = pulse;
        if (tmr_done) begin
          state_nx = OFF;
          tmr_load = 1'b1;
          tmr_val  = OFF_LOAD;
        end
      end
      OFF: begin
        queue_req = pulse;
        if (tmr_done) begin
          if ((pend_q != '0) || pulse) begin
            state_nx = ON;
            tmr_load = 1'b1;
            consume  = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef LED_PULSE_STRETCHER_QUEUE_EN
  logic [PW-1:0] pend_nx;

  // A pulse landing on the consuming cycle takes the slot just freed.
  always_comb begin
    pend_nx = pend_q;
    drop_nx = 1'b0;
    if (consume) begin
      if ((pend_q != '0) && !pulse)
        pend_nx = pend_q - PW'(1);
    end else if (queue_req) begin
      if (pend_q < PW'(QUEUE_MAX))
        pend_nx = pend_q + PW'(1);
      else
        drop_nx = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      pend_q <= '0;
    else
      pend_q <= pend_nx;
  end
`else
  assign pend_q  = '0;
  assign drop_nx = queue_req && !consume;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      led     <= 1'b0;
      busy    <= 1'b0;
      dropped <= 1'b0;
    end else begin
      state   <= state_nx;
      led     <= (state_nx == ON);
      busy    <= (state_nx != IDLE);
      dropped <= drop_nx;
    end
  end

  assign pending = pend_q;

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Directed and random bench for led_pulse_stretcher; follows LED_PULSE_STRETCHER_QUEUE_EN.
module tb_led_pulse_stretcher;
  import led_ind_pkg::*;

  localparam int unsigned ON  = 4;
  localparam int unsigned OFF = 3;
  localparam int unsigned QM  = 2;
  localparam int unsigned PW  = $clog2(QM + 1);
`ifdef LED_PULSE_STRETCHER_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, pulse, led, busy, dropped;
  logic [PW-1:0] pending;

  always #5 clk = ~clk;

  led_pulse_stretcher #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .QUEUE_MAX(QM)) dut (
    .clk     (clk),
    .rst     (rst),
    .pulse   (pulse),
    .led     (led),
    .busy    (busy),
    .pending (pending),
    .dropped (dropped)
  );

  typedef struct packed {
    logic          led;
    logic          busy;
    logic [PW-1:0] pend;
    logic          drop;
  } exp_t;

  exp_t exp_q[$];
  int n_pass = 0, n_fail = 0, n_total = 0;
  int cyc;
  logic          led_h  [0:63];
  logic          busy_h [0:63];
  logic          drop_h [0:63];
  logic [PW-1:0] pend_h [0:63];

  // Reference: phase 0 idle, 1 lit, 2 dark; left = cycles remaining in phase.
  int m_ph = 0, m_left = 0, m_q = 0;
  bit m_drop = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  task automatic m_enqueue();
    if (QEN && (m_q < int'(QM))) m_q++;
    else m_drop = 1'b1;
  endtask

  task automatic model(input bit p, input bit r);
    m_drop = 1'b0;
    if (r) begin
      m_ph = 0; m_left = 0; m_q = 0;
    end else begin
      case (m_ph)
        0: if (p) begin m_ph = 1; m_left = ON; end
        1: begin
          if (p) m_enqueue();
          m_left--;
          if (m_left == 0) begin m_ph = 2; m_left = OFF; end
        end
        default: begin
          if (m_left == 1 && (m_q > 0 || p)) begin
            m_ph = 1; m_left = ON;
            if (m_q > 0 && !p) m_q--;
          end else begin
            if (p) m_enqueue();
            m_left--;
            if (m_left == 0) m_ph = 0;
          end
        end
      endcase
    end
  endtask

  task automatic step(input bit p, input bit r);
    exp_t e;
    pulse = p;
    rst   = r;
    model(p, r);
    e.led  = (m_ph == 1);
    e.busy = (m_ph != 0);
    e.pend = PW'(m_q);
    e.drop = m_drop;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    e = exp_q.pop_front();
    chk($sformatf("led@%0d", cyc),  {7'd0, led},     {7'd0, e.led});
    chk($sformatf("busy@%0d", cyc), {7'd0, busy},    {7'd0, e.busy});
    chk($sformatf("pend@%0d", cyc), 8'(pending),     8'(e.pend));
    chk($sformatf("drop@%0d", cyc), {7'd0, dropped}, {7'd0, e.drop});
    if (cyc < 64) begin
      led_h[cyc] = led; busy_h[cyc] = busy; drop_h[cyc] = dropped; pend_h[cyc] = pending;
    end
  endtask

  task automatic start_scn();
    cyc = 0;
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
  endtask

  task automatic run_to(input int k);
    while (cyc < k) step(1'b0, 1'b0);
  endtask

  task automatic pulse_at(input int k);
    run_to(k);
    step(1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    pulse = 1'b0;
    cyc = 0;

    // single blink timing
    start_scn();
    chk("rst_led",  {7'd0, led_h[2]},  8'd0);
    chk("rst_busy", {7'd0, busy_h[2]}, 8'd0);
    chk("rst_pend", 8'(pend_h[2]),     8'd0);
    pulse_at(10);
    run_to(20);
    chk("s1_led10", {7'd0, led_h[10]}, 8'd0);
    for (int c = 11; c <= 14; c++) chk($sformatf("s1_on%0d", c), {7'd0, led_h[c]}, 8'd1);
    for (int c = 15; c <= 17; c++) chk($sformatf("s1_off%0d", c), {7'd0, led_h[c]}, 8'd0);
    for (int c = 11; c <= 17; c++) chk($sformatf("s1_busy%0d", c), {7'd0, busy_h[c]}, 8'd1);
    chk("s1_idle18", {7'd0, busy_h[18]}, 8'd0);

    // three extra pulses during the first blink
    start_scn();
    pulse_at(10); pulse_at(11); pulse_at(12); pulse_at(13);
    run_to(34);
`ifdef LED_PULSE_STRETCHER_QUEUE_EN
    chk("s2_pend12", 8'(pend_h[12]), 8'd1);
    chk("s2_pend13", 8'(pend_h[13]), 8'd2);
    chk("s2_pend14", 8'(pend_h[14]), 8'd2);
    chk("s2_drop13", {7'd0, drop_h[13]}, 8'd0);
    chk("s2_drop14", {7'd0, drop_h[14]}, 8'd1);
    chk("s2_drop15", {7'd0, drop_h[15]}, 8'd0);
    for (int c = 18; c <= 21; c++) chk($sformatf("s2_b2_%0d", c), {7'd0, led_h[c]}, 8'd1);
    for (int c = 25; c <= 28; c++) chk($sformatf("s2_b3_%0d", c), {7'd0, led_h[c]}, 8'd1);
    chk("s2_led24",  {7'd0, led_h[24]}, 8'd0);
    chk("s2_pend18", 8'(pend_h[18]), 8'd1);
    chk("s2_pend25", 8'(pend_h[25]), 8'd0);
    chk("s2_busy31", {7'd0, busy_h[31]}, 8'd1);
    chk("s2_busy32", {7'd0, busy_h[32]}, 8'd0);
`else
    for (int c = 12; c <= 14; c++) chk($sformatf("s2_drop%0d", c), {7'd0, drop_h[c]}, 8'd1);
    chk("s2_drop15", {7'd0, drop_h[15]}, 8'd0);
    chk("s2_pend13", 8'(pend_h[13]), 8'd0);
    chk("s2_led18",  {7'd0, led_h[18]}, 8'd0);
    chk("s2_busy18", {7'd0, busy_h[18]}, 8'd0);
`endif

    // pulse in the final dark cycle, empty queue
    start_scn();
    pulse_at(10); pulse_at(17);
    run_to(26);
    chk("s3_led18",  {7'd0, led_h[18]},  8'd1);
    chk("s3_pend18", 8'(pend_h[18]),     8'd0);
    chk("s3_drop18", {7'd0, drop_h[18]}, 8'd0);
    chk("s3_led21",  {7'd0, led_h[21]},  8'd1);
    chk("s3_led22",  {7'd0, led_h[22]},  8'd0);

    // pulse in the final dark cycle, full queue
    start_scn();
    pulse_at(10); pulse_at(11); pulse_at(12); pulse_at(17);
    run_to(40);
`ifdef LED_PULSE_STRETCHER_QUEUE_EN
    chk("s4_pend17", 8'(pend_h[17]),     8'd2);
    chk("s4_pend18", 8'(pend_h[18]),     8'd2);
    chk("s4_drop18", {7'd0, drop_h[18]}, 8'd0);
    chk("s4_led18",  {7'd0, led_h[18]},  8'd1);
`endif

    // reset mid-blink
    start_scn();
    pulse_at(10); pulse_at(11);
    run_to(12);
    step(1'b1, 1'b1);
    chk("s5_led13",  {7'd0, led_h[13]},  8'd0);
    chk("s5_busy13", {7'd0, busy_h[13]}, 8'd0);
    chk("s5_pend13", 8'(pend_h[13]),     8'd0);
    pulse_at(15);
    run_to(24);
    for (int c = 16; c <= 19; c++) chk($sformatf("s5_on%0d", c), {7'd0, led_h[c]}, 8'd1);
    chk("s5_led20", {7'd0, led_h[20]}, 8'd0);
    chk("s5_idle23", {7'd0, busy_h[23]}, 8'd0);

    // random strobes with occasional reset
    start_scn();
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 79) == 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
